// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU issue scheduler: FPU interface
// widths and command codes, command classification and latency helpers.
package fpu_sched_pkg;

  // FPU interface widths and command encodings, mirrored from fpu_defs
  localparam int C_OP    = 32;
  localparam int C_RM    = 3;
  localparam int C_CMD   = 4;
  localparam int C_PC    = 5;
  localparam int C_FFLAG = 5;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
  localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
  localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
  localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
  localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
  localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
  localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

  // invalid-operation flag position and the flag word returned for illegal commands
  localparam int                  FLAG_NV = 4;
  localparam logic [C_FFLAG-1:0]  NV_FLAG = C_FFLAG'(1 << FLAG_NV);

  typedef enum logic [1:0] {
    CLS_CORE,
    CLS_FMA,
    CLS_DSQ,
    CLS_ILLEGAL
  } cmd_cls_e;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LAT_CORE_DEF = 2;
  localparam int LAT_FMA_DEF  = 3;
  localparam int LAT_MAX      = lat_max(LAT_CORE_DEF, LAT_FMA_DEF);

  function automatic cmd_cls_e classify(input logic [C_CMD-1:0] cmd);
    cmd_cls_e cls;
    case (cmd)
      C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD,
      C_FPU_I2F_CMD, C_FPU_F2I_CMD:                   cls = CLS_CORE;
      C_FPU_FMADD_CMD, C_FPU_FMSUB_CMD,
      C_FPU_FNMADD_CMD, C_FPU_FNMSUB_CMD:             cls = CLS_FMA;
      C_FPU_DIV_CMD, C_FPU_SQRT_CMD:                  cls = CLS_DSQ;
      default:                                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/fpu_issue_sched_rr_arb.sv
// Round-robin arbiter: grants the first eligible requester at or after the
// pointer (wrapping) and returns the pointer for the following cycle.
module fpu_rr_arb
  import fpu_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] ptr_next
);

  logic         found;
  logic [W-1:0] idx;

  // scan from ptr upward, wrapping, and stop at the first eligible index
  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!found && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = (int'(idx) == N - 1) ? '0 : idx + W'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_issue_sched.sv
// Issue scheduler sharing one FPU among NB_REQ requesters. A latency
// reservation table guarantees results never collide at the FPU output and
// remembers which requester each result belongs to; div/sqrt runs alone.
module fpu_issue_sched
  import fpu_sched_pkg::*;
#(
  parameter int NB_REQ   = 4,
  parameter int LAT_CORE = LAT_CORE_DEF,
  parameter int LAT_FMA  = LAT_FMA_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NB_REQ-1:0]       req_i,
  input  logic [NB_REQ*C_OP-1:0]  req_op_a_i,
  input  logic [NB_REQ*C_OP-1:0]  req_op_b_i,
  input  logic [NB_REQ*C_OP-1:0]  req_op_c_i,
  input  logic [NB_REQ*C_RM-1:0]  req_rm_i,
  input  logic [NB_REQ*C_CMD-1:0] req_cmd_i,
  input  logic [NB_REQ*C_PC-1:0]  req_prec_i,
  output logic [NB_REQ-1:0]       gnt_o,
  output logic [NB_REQ-1:0]       resp_valid_o,
  output logic [C_OP-1:0]         resp_result_o,
  output logic [C_FFLAG-1:0]      resp_flags_o,
  output logic                    fpu_en_o,
  output logic [C_OP-1:0]         fpu_op_a_o,
  output logic [C_OP-1:0]         fpu_op_b_o,
  output logic [C_OP-1:0]         fpu_op_c_o,
  output logic [C_RM-1:0]         fpu_rm_o,
  output logic [C_CMD-1:0]        fpu_cmd_o,
  output logic [C_PC-1:0]         fpu_prec_o,
  input  logic [C_OP-1:0]         fpu_result_i,
  input  logic                    fpu_valid_i,
  input  logic [C_FFLAG-1:0]      fpu_flags_i,
  input  logic                    fpu_divsqrt_busy_i,
  output logic                    err_o
);

  localparam int SLOTS = lat_max(LAT_CORE, LAT_FMA);
  localparam int IDW   = $clog2(NB_REQ);

  // slot k holds the result expected k cycles from now
  logic [SLOTS:1]  res_v, res_ill, sh_v, sh_ill, nxt_v, nxt_ill;
  logic [IDW-1:0]  res_id [1:SLOTS];
  logic [IDW-1:0]  sh_id  [1:SLOTS];
  logic [IDW-1:0]  nxt_id [1:SLOTS];

  logic [IDW-1:0]  rr_ptr, rr_next;
  logic            dsq_pend;
  logic [IDW-1:0]  dsq_id;
  logic            err_q;

  cmd_cls_e          cls [NB_REQ];
  logic [NB_REQ-1:0] elig, gnt;
  logic              any_gnt, dsq_done, dsq_blk, tbl_empty, issue_fix, issue_dsq;
  cmd_cls_e          g_cls;
  logic [IDW-1:0]    g_idx;
  logic [C_OP-1:0]   g_a, g_b, g_c;
  logic [C_RM-1:0]   g_rm;
  logic [C_CMD-1:0]  g_cmd;
  logic [C_PC-1:0]   g_prec;

  logic              rsp_hit, rsp_fwd, rsp_ill, err_now;
  logic [IDW-1:0]    rsp_id;

  // table as seen after this cycle's shift
  always_comb begin
    sh_v   = {1'b0, res_v[SLOTS:2]};
    sh_ill = {1'b0, res_ill[SLOTS:2]};
    for (int k = 1; k < SLOTS; k++) sh_id[k] = res_id[k+1];
    sh_id[SLOTS] = '0;
  end

  // a div/sqrt that completes this cycle releases the issue path immediately
  assign dsq_done  = dsq_pend & fpu_valid_i & ~res_v[1];
  assign dsq_blk   = dsq_pend & ~dsq_done;
  assign tbl_empty = ~|sh_v;

  // per-requester class and eligibility; a single grant per cycle means a
  // granted div/sqrt can never coincide with a fixed-latency grant
  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      cls[i] = classify(req_cmd_i[i*C_CMD +: C_CMD]);
      case (cls[i])
        CLS_CORE: elig[i] = ~sh_v[LAT_CORE];
        CLS_FMA:  elig[i] = ~sh_v[LAT_FMA];
        CLS_DSQ:  elig[i] = tbl_empty & ~fpu_divsqrt_busy_i;
        default:  elig[i] = ~sh_v[1];
      endcase
      elig[i] = elig[i] & req_i[i] & ~dsq_blk & ~rst_i;
    end
  end

  fpu_rr_arb #(.N(NB_REQ), .W(IDW)) u_arb (
    .elig     (elig),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .ptr_next (rr_next)
  );

  // select the granted requester's payload from the one-hot grant
  always_comb begin
    g_cls  = CLS_CORE;
    g_idx  = '0;
    g_a    = '0;
    g_b    = '0;
    g_c    = '0;
    g_rm   = '0;
    g_cmd  = '0;
    g_prec = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (gnt[i]) begin
        g_cls  = cls[i];
        g_idx  = IDW'(i);
        g_a    = req_op_a_i[i*C_OP +: C_OP];
        g_b    = req_op_b_i[i*C_OP +: C_OP];
        g_c    = req_op_c_i[i*C_OP +: C_OP];
        g_rm   = req_rm_i[i*C_RM +: C_RM];
        g_cmd  = req_cmd_i[i*C_CMD +: C_CMD];
        g_prec = req_prec_i[i*C_PC +: C_PC];
      end
    end
  end

  assign any_gnt    = |gnt;
  assign issue_dsq  = any_gnt & (g_cls == CLS_DSQ);
  assign issue_fix  = any_gnt & (g_cls != CLS_DSQ);
  assign gnt_o      = gnt;
  assign fpu_en_o   = any_gnt & (g_cls != CLS_ILLEGAL);
  assign fpu_op_a_o = fpu_en_o ? g_a    : '0;
  assign fpu_op_b_o = fpu_en_o ? g_b    : '0;
  assign fpu_op_c_o = fpu_en_o ? g_c    : '0;
  assign fpu_rm_o   = fpu_en_o ? g_rm   : '0;
  assign fpu_cmd_o  = fpu_en_o ? g_cmd  : '0;
  assign fpu_prec_o = fpu_en_o ? g_prec : '0;

  // reserve the result slot of a newly granted fixed-latency or illegal op
  always_comb begin
    nxt_v   = sh_v;
    nxt_ill = sh_ill;
    nxt_id  = sh_id;
    if (issue_fix) begin
      case (g_cls)
        CLS_CORE: begin
          nxt_v[LAT_CORE]   = 1'b1;
          nxt_ill[LAT_CORE] = 1'b0;
          nxt_id[LAT_CORE]  = g_idx;
        end
        CLS_FMA: begin
          nxt_v[LAT_FMA]    = 1'b1;
          nxt_ill[LAT_FMA]  = 1'b0;
          nxt_id[LAT_FMA]   = g_idx;
        end
        default: begin
          nxt_v[1]          = 1'b1;
          nxt_ill[1]        = 1'b1;
          nxt_id[1]         = g_idx;
        end
      endcase
    end
  end

  // match the table head or pending div/sqrt against fpu_valid_i
  always_comb begin
    rsp_hit = 1'b0;
    rsp_fwd = 1'b0;
    rsp_ill = 1'b0;
    rsp_id  = '0;
    err_now = 1'b0;
    if (!rst_i) begin
      if (res_v[1]) begin
        rsp_id = res_id[1];
        if (res_ill[1]) begin
          rsp_hit = 1'b1;
          rsp_ill = 1'b1;
          err_now = fpu_valid_i;
        end else if (fpu_valid_i) begin
          rsp_hit = 1'b1;
          rsp_fwd = 1'b1;
        end else begin
          err_now = 1'b1;
        end
      end else if (fpu_valid_i) begin
        if (dsq_pend) begin
          rsp_hit = 1'b1;
          rsp_fwd = 1'b1;
          rsp_id  = dsq_id;
        end else begin
          err_now = 1'b1;
        end
      end
    end
  end

  // decode the response id into the one-hot strobe and drive shared data
  always_comb begin
    for (int i = 0; i < NB_REQ; i++) resp_valid_o[i] = rsp_hit && (rsp_id == IDW'(i));
    resp_result_o = rsp_fwd ? fpu_result_i : '0;
    resp_flags_o  = rsp_fwd ? fpu_flags_i  : (rsp_ill ? NV_FLAG : '0);
  end

  assign err_o = err_q;

  // scheduler state: pointer, reservation table, div/sqrt tracking, error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      res_v    <= '0;
      res_ill  <= '0;
      for (int k = 1; k <= SLOTS; k++) res_id[k] <= '0;
      dsq_pend <= 1'b0;
      dsq_id   <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr  <= rr_next;
      res_v   <= nxt_v;
      res_ill <= nxt_ill;
      for (int k = 1; k <= SLOTS; k++) res_id[k] <= nxt_id[k];
      if (issue_dsq) begin
        dsq_pend <= 1'b1;
        dsq_id   <= g_idx;
      end else if (dsq_done) begin
        dsq_pend <= 1'b0;
      end
      err_q <= err_q | err_now;
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched; the bench plays the FPU, returning
// hand-computed results on the cycles the fixed latencies dictate.
module tb_fpu_issue_sched;
  import fpu_sched_pkg::*;

  localparam int NB = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NB-1:0]        req_i;
  logic [NB*C_OP-1:0]   req_op_a_i, req_op_b_i, req_op_c_i;
  logic [NB*C_RM-1:0]   req_rm_i;
  logic [NB*C_CMD-1:0]  req_cmd_i;
  logic [NB*C_PC-1:0]   req_prec_i;
  logic [NB-1:0]        gnt_o, resp_valid_o;
  logic [C_OP-1:0]      resp_result_o;
  logic [C_FFLAG-1:0]   resp_flags_o;
  logic                 fpu_en_o;
  logic [C_OP-1:0]      fpu_op_a_o, fpu_op_b_o, fpu_op_c_o;
  logic [C_RM-1:0]      fpu_rm_o;
  logic [C_CMD-1:0]     fpu_cmd_o;
  logic [C_PC-1:0]      fpu_prec_o;
  logic [C_OP-1:0]      fpu_result_i;
  logic                 fpu_valid_i;
  logic [C_FFLAG-1:0]   fpu_flags_i;
  logic                 fpu_divsqrt_busy_i;
  logic                 err_o;

  int n_cmp, n_bad;
  logic [3:0] exp_g [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

  always #5 clk_i = ~clk_i;

  fpu_issue_sched #(.NB_REQ(NB), .LAT_CORE(2), .LAT_FMA(3)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_i              (req_i),
    .req_op_a_i         (req_op_a_i),
    .req_op_b_i         (req_op_b_i),
    .req_op_c_i         (req_op_c_i),
    .req_rm_i           (req_rm_i),
    .req_cmd_i          (req_cmd_i),
    .req_prec_i         (req_prec_i),
    .gnt_o              (gnt_o),
    .resp_valid_o       (resp_valid_o),
    .resp_result_o      (resp_result_o),
    .resp_flags_o       (resp_flags_o),
    .fpu_en_o           (fpu_en_o),
    .fpu_op_a_o         (fpu_op_a_o),
    .fpu_op_b_o         (fpu_op_b_o),
    .fpu_op_c_o         (fpu_op_c_o),
    .fpu_rm_o           (fpu_rm_o),
    .fpu_cmd_o          (fpu_cmd_o),
    .fpu_prec_o         (fpu_prec_o),
    .fpu_result_i       (fpu_result_i),
    .fpu_valid_i        (fpu_valid_i),
    .fpu_flags_i        (fpu_flags_i),
    .fpu_divsqrt_busy_i (fpu_divsqrt_busy_i),
    .err_o              (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [C_CMD-1:0] cmd,
                         input logic [C_OP-1:0] a, input logic [C_OP-1:0] b,
                         input logic [C_OP-1:0] c);
    req_i[i]                   = 1'b1;
    req_cmd_i[i*C_CMD +: C_CMD] = cmd;
    req_op_a_i[i*C_OP +: C_OP]  = a;
    req_op_b_i[i*C_OP +: C_OP]  = b;
    req_op_c_i[i*C_OP +: C_OP]  = c;
  endtask

  task automatic fpu_ret(input logic v, input logic [C_OP-1:0] r, input logic [C_FFLAG-1:0] f);
    fpu_valid_i  = v;
    fpu_result_i = r;
    fpu_flags_i  = f;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_i = 1'b1;
    req_i = '0;
    req_op_a_i = '0; req_op_b_i = '0; req_op_c_i = '0;
    req_rm_i = '0; req_cmd_i = '0; req_prec_i = '0;
    fpu_ret(1'b0, '0, '0);
    fpu_divsqrt_busy_i = 1'b0;

    // reset: a request present during reset must not be granted
    cyc(); set_req(0, C_FPU_ADD_CMD, 32'h3F800000, 32'h40000000, 32'h0); settle();
    chk("rst_gnt", gnt_o, 4'b0000);
    chk("rst_en", fpu_en_o, 1'b0);
    cyc(); settle();
    chk("rst_resp", resp_valid_o, 4'b0000);
    chk("rst_err", err_o, 1'b0);
    chk("rst_opa", fpu_op_a_o, 32'h0);
    chk("rst_result", resp_result_o, 32'h0);

    // 1.0 + 2.0 on req0, result two cycles after issue
    cyc(); rst_i = 1'b0; settle();
    chk("add_gnt", gnt_o, 4'b0001);
    chk("add_en", fpu_en_o, 1'b1);
    chk("add_opa", fpu_op_a_o, 32'h3F800000);
    chk("add_opb", fpu_op_b_o, 32'h40000000);
    chk("add_cmd", fpu_cmd_o, C_FPU_ADD_CMD);
    cyc(); req_i[0] = 1'b0; settle();
    chk("add_t1_resp", resp_valid_o, 4'b0000);
    chk("add_t1_gnt", gnt_o, 4'b0000);
    chk("add_t1_en", fpu_en_o, 1'b0);
    cyc(); fpu_ret(1'b1, 32'h40400000, 5'h00); settle();
    chk("add_resp", resp_valid_o, 4'b0001);
    chk("add_result", resp_result_o, 32'h40400000);
    chk("add_flags", resp_flags_o, 5'h00);
    cyc(); fpu_ret(1'b0, 32'h0, 5'h00); settle();
    chk("add_t3_resp", resp_valid_o, 4'b0000);
    chk("add_t3_result", resp_result_o, 32'h0);

    // FMA on req0 then MUL on req1 colliding at the same slot: MUL slips a cycle
    cyc(); set_req(0, C_FPU_FMADD_CMD, 32'h3F800000, 32'h40000000, 32'h40400000); settle();
    chk("fma_gnt", gnt_o, 4'b0001);
    chk("fma_cmd", fpu_cmd_o, C_FPU_FMADD_CMD);
    chk("fma_opc", fpu_op_c_o, 32'h40400000);
    cyc(); req_i[0] = 1'b0; set_req(1, C_FPU_MUL_CMD, 32'h40000000, 32'h40400000, 32'h0); settle();
    chk("mul_stall_gnt", gnt_o, 4'b0000);
    chk("mul_stall_en", fpu_en_o, 1'b0);
    cyc(); settle();
    chk("mul_gnt", gnt_o, 4'b0010);
    chk("mul_cmd", fpu_cmd_o, C_FPU_MUL_CMD);
    cyc(); req_i[1] = 1'b0; fpu_ret(1'b1, 32'h40A00000, 5'h00); settle();
    chk("fma_resp", resp_valid_o, 4'b0001);
    chk("fma_result", resp_result_o, 32'h40A00000);
    cyc(); fpu_ret(1'b1, 32'h40C00000, 5'h01); settle();
    chk("mul_resp", resp_valid_o, 4'b0010);
    chk("mul_result", resp_result_o, 32'h40C00000);
    chk("mul_flags", resp_flags_o, 5'h01);
    cyc(); fpu_ret(1'b0, 32'h0, 5'h00); settle();
    chk("mul_done_resp", resp_valid_o, 4'b0000);

    // all four requesters stream ADDs; pointer is at 2 from the MUL grant
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k < 5) begin
        for (int j = 0; j < NB; j++)
          set_req(j, C_FPU_ADD_CMD, 32'h40000000 + j, 32'h3F800000, 32'h0);
      end else begin
        req_i = '0;
      end
      if (k >= 2) fpu_ret(1'b1, 32'h41000000 + k, 5'h00);
      else        fpu_ret(1'b0, 32'h0, 5'h00);
      settle();
      if (k < 5) chk("rot_gnt", gnt_o, exp_g[k]);
      else       chk("rot_idle_gnt", gnt_o, 4'b0000);
      if (k >= 2) begin
        chk("rot_resp", resp_valid_o, exp_g[k-2]);
        chk("rot_result", resp_result_o, 32'h41000000 + k);
      end else begin
        chk("rot_noresp", resp_valid_o, 4'b0000);
      end
    end
    cyc(); fpu_ret(1'b0, 32'h0, 5'h00); settle();
    chk("rot_err", err_o, 1'b0);
    chk("rot_end_resp", resp_valid_o, 4'b0000);

    // 3.0 / 2.0 on req2 blocks req3's ADD until the division returns
    cyc(); set_req(2, C_FPU_DIV_CMD, 32'h40400000, 32'h40000000, 32'h0); settle();
    chk("div_gnt", gnt_o, 4'b0100);
    chk("div_en", fpu_en_o, 1'b1);
    chk("div_cmd", fpu_cmd_o, C_FPU_DIV_CMD);
    cyc(); req_i[2] = 1'b0; fpu_divsqrt_busy_i = 1'b1;
    set_req(3, C_FPU_ADD_CMD, 32'h3F800000, 32'h3F800000, 32'h0); settle();
    chk("div_block_gnt1", gnt_o, 4'b0000);
    cyc(); settle();
    chk("div_block_gnt2", gnt_o, 4'b0000);
    cyc(); settle();
    chk("div_block_gnt3", gnt_o, 4'b0000);
    cyc(); fpu_divsqrt_busy_i = 1'b0; fpu_ret(1'b1, 32'h3FC00000, 5'h00); settle();
    chk("div_resp", resp_valid_o, 4'b0100);
    chk("div_result", resp_result_o, 32'h3FC00000);
    chk("div_resume_gnt", gnt_o, 4'b1000);
    cyc(); req_i[3] = 1'b0; fpu_ret(1'b0, 32'h0, 5'h00); settle();
    chk("div_gap_resp", resp_valid_o, 4'b0000);
    cyc(); fpu_ret(1'b1, 32'h40000000, 5'h00); settle();
    chk("div_add_resp", resp_valid_o, 4'b1000);
    chk("div_add_result", resp_result_o, 32'h40000000);
    cyc(); fpu_ret(1'b0, 32'h0, 5'h00); settle();
    chk("div_err", err_o, 1'b0);

    // illegal command on req1: granted without FPU issue, NV response next cycle
    cyc(); set_req(1, C_FPU_NOP_CMD, 32'h3F800000, 32'h0, 32'h0); settle();
    chk("ill_gnt", gnt_o, 4'b0010);
    chk("ill_en", fpu_en_o, 1'b0);
    chk("ill_opa", fpu_op_a_o, 32'h0);
    cyc(); req_i[1] = 1'b0; settle();
    chk("ill_resp", resp_valid_o, 4'b0010);
    chk("ill_result", resp_result_o, 32'h0);
    chk("ill_flags", resp_flags_o, 5'h10);
    cyc(); settle();
    chk("ill_after_resp", resp_valid_o, 4'b0000);
    chk("ill_err", err_o, 1'b0);

    // stray fpu_valid_i with nothing expected
    cyc(); fpu_ret(1'b1, 32'hDEADBEEF, 5'h00); settle();
    chk("stray_resp", resp_valid_o, 4'b0000);
    chk("stray_result", resp_result_o, 32'h0);
    chk("stray_err_pre", err_o, 1'b0);
    cyc(); fpu_ret(1'b0, 32'h0, 5'h00); settle();
    chk("stray_err", err_o, 1'b1);
    cyc(); settle();
    chk("stray_err_sticky", err_o, 1'b1);

    // reset with two ops in flight
    cyc(); set_req(0, C_FPU_ADD_CMD, 32'h3F800000, 32'h3F800000, 32'h0); settle();
    chk("rm_gnt0", gnt_o, 4'b0001);
    cyc(); req_i[0] = 1'b0; set_req(1, C_FPU_SUB_CMD, 32'h40000000, 32'h3F800000, 32'h0); settle();
    chk("rm_gnt1", gnt_o, 4'b0010);
    cyc(); req_i[1] = 1'b0; rst_i = 1'b1; settle();
    chk("rm_rst_resp", resp_valid_o, 4'b0000);
    chk("rm_rst_gnt", gnt_o, 4'b0000);
    cyc(); rst_i = 1'b0; settle();
    chk("rm_err", err_o, 1'b0);
    chk("rm_resp", resp_valid_o, 4'b0000);
    chk("rm_result", resp_result_o, 32'h0);
    chk("rm_en", fpu_en_o, 1'b0);
    cyc(); settle();
    chk("rm_err_late", err_o, 1'b0);
    chk("rm_resp_late", resp_valid_o, 4'b0000);

    // pointer restarted at 0: req1 wins over req3
    cyc();
    set_req(1, C_FPU_ADD_CMD, 32'h3F800000, 32'h40000000, 32'h0);
    set_req(3, C_FPU_ADD_CMD, 32'h40000000, 32'h40000000, 32'h0);
    settle();
    chk("post_gnt1", gnt_o, 4'b0010);
    chk("post_opa1", fpu_op_a_o, 32'h3F800000);
    cyc(); req_i[1] = 1'b0; settle();
    chk("post_gnt3", gnt_o, 4'b1000);
    cyc(); req_i[3] = 1'b0; fpu_ret(1'b1, 32'h40400000, 5'h00); settle();
    chk("post_resp1", resp_valid_o, 4'b0010);
    chk("post_result1", resp_result_o, 32'h40400000);
    cyc(); fpu_ret(1'b1, 32'h40800000, 5'h00); settle();
    chk("post_resp3", resp_valid_o, 4'b1000);
    chk("post_result3", resp_result_o, 32'h40800000);
    cyc(); fpu_ret(1'b0, 32'h0, 5'h00); settle();
    chk("post_err", err_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
